// File: rtl/global_io_accum_if.sv
// Purpose : bundles the beat input side and the result output side of
//           global_io_accum into one port.
// Ports   : macout/signed_op/in_valid/in_ready carry bit-serial beats in,
//           out_data/out_valid/out_ready carry finished results out.
//           sub_mask exists only when GIO_PAIR_SUB_EN is defined.
// master = producer of beats and consumer of results; slave = the accumulator.
interface global_io_accum_if #(
  parameter int NUM_MACS      = 4,
  parameter int PSUM_WIDTH    = 12,
  parameter int GIO_OUT_WIDTH = 27
);

  logic [NUM_MACS*PSUM_WIDTH-1:0] macout;
  logic                           signed_op;
  logic                           in_valid;
  logic                           in_ready;
`ifdef GIO_PAIR_SUB_EN
  logic [NUM_MACS-1:0]            sub_mask;
`endif
  logic [GIO_OUT_WIDTH-1:0]       out_data;
  logic                           out_valid;
  logic                           out_ready;

`ifdef GIO_PAIR_SUB_EN
  modport master (
    output macout, signed_op, in_valid, sub_mask, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  macout, signed_op, in_valid, sub_mask, out_ready,
    output in_ready, out_data, out_valid
  );
`else
  modport master (
    output macout, signed_op, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  macout, signed_op, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
`endif

endinterface

// File: rtl/global_io_accum.sv
// Purpose     : sums NUM_MACS signed partial sums per beat through an adder tree and
//               shift-accumulates IN_BITS bit-serial beats (MSB first) into one result.
// Latency     : last beat accepted in cycle T -> out_valid in cycle T+2; one beat/cycle.
// Backpressure: a held result (out_valid && !out_ready) stalls the whole pipe and drops in_ready.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous flush of counter, accumulator and both valid stages
//   bus         global_io_accum_if.slave: macout/signed_op/in_valid/in_ready beats in,
//               out_data/out_valid/out_ready results out (plus sub_mask, see below)
//   busy        a vector is partially accepted or stage 1 holds a beat
//
// Optional feature: define GIO_PAIR_SUB_EN to add bus.sub_mask; psum i is negated before
// the reduction when sub_mask[i]=1. Without the macro every psum is added.
module global_io_accum #(
  parameter int NUM_MACS      = 4,
  parameter int PSUM_WIDTH    = 12,
  parameter int GIO_OUT_WIDTH = 27,
  parameter int IN_BITS       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  global_io_accum_if.slave   bus,
  output logic               busy
);

  // Tree sum width: each doubling of the operand count adds one bit of growth.
  localparam int SUM_W = PSUM_WIDTH + $clog2(NUM_MACS);
  localparam int CNT_W = $clog2(IN_BITS);
  // Heap-ordered tree: node n has children 2n+1 and 2n+2; leaves occupy the top
  // NUM_MACS slots, root is node 0.
  localparam int NODES = 2*NUM_MACS - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_BITS - 1);

  // ------------------------------------------------------------------
  // Per-channel add/subtract selection
  // ------------------------------------------------------------------
  logic [NUM_MACS-1:0] sub_sel;

`ifdef GIO_PAIR_SUB_EN
  assign sub_sel = bus.sub_mask;
`else
  assign sub_sel = '0;
`endif

  // ------------------------------------------------------------------
  // Adder tree (combinational, result registered in stage 1)
  // ------------------------------------------------------------------
  logic signed [SUM_W-1:0]         tree [NODES];
  logic signed [GIO_OUT_WIDTH-1:0] beat_sum;

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      tree[n] = '0;
    end
    // Leaves: sign-extend each psum to the full tree width first so that
    // negating the most negative psum cannot overflow.
    for (int i = 0; i < NUM_MACS; i++) begin
      tree[NUM_MACS-1+i] = SUM_W'($signed(bus.macout[i*PSUM_WIDTH +: PSUM_WIDTH]));
      if (sub_sel[i]) begin
        tree[NUM_MACS-1+i] = -tree[NUM_MACS-1+i];
      end
    end
    // Inner nodes, children before parents.
    for (int n = NUM_MACS-2; n >= 0; n--) begin
      tree[n] = tree[2*n+1] + tree[2*n+2];
    end
  end

  // Signed cast keeps the sign when widening to the accumulator width.
  assign beat_sum = GIO_OUT_WIDTH'(tree[0]);

  // ------------------------------------------------------------------
  // Flow control
  // ------------------------------------------------------------------
  logic adv;
  logic first_beat;
  logic last_beat;

  // Only a result that is offered and refused stalls the pipe.
  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = adv;

  // ------------------------------------------------------------------
  // Stage 1: beat counter, registered tree sum and its tags
  // ------------------------------------------------------------------
  logic [CNT_W-1:0]         cnt;
  logic                     s1_vld;
  logic                     s1_first;
  logic                     s1_last;
  logic                     s1_neg;
  logic [GIO_OUT_WIDTH-1:0] s1_sum;

  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_sum   <= '0;
    end else if (clear) begin
      // A beat offered alongside clear is dropped: nothing below loads.
      cnt    <= '0;
      s1_vld <= 1'b0;
    end else if (adv) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum   <= beat_sum;
        s1_first <= first_beat;
        s1_last  <= last_beat;
        // signed_op only matters on the first beat; later beats ignore it.
        s1_neg   <= first_beat && bus.signed_op;
        cnt      <= last_beat ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: shift-accumulate and result register
  // ------------------------------------------------------------------
  logic [GIO_OUT_WIDTH-1:0] acc;
  logic [GIO_OUT_WIDTH-1:0] acc_next;
  logic [GIO_OUT_WIDTH-1:0] out_data_q;
  logic                     out_valid_q;

  // MSB arrives first, so each earlier partial doubles as a new beat comes in.
  // The first beat restarts from zero, which lets vectors run back to back.
  // A signed vector's MSB beat carries negative weight. Wraps modulo 2^width.
  assign acc_next = (s1_first ? '0 : (acc << 1)) + (s1_neg ? -s1_sum : s1_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      acc         <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      if (s1_vld) begin
        acc <= acc_next;
      end
      // With adv high any offered result is being taken this cycle, so
      // out_valid either drops or is immediately refilled by a new result.
      out_valid_q <= s1_vld && s1_last;
      if (s1_vld && s1_last) begin
        out_data_q <= acc_next;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  assign busy = (cnt != '0) || s1_vld;

endmodule

// File: tb/tb_global_io_accum.sv
module tb_global_io_accum;

  localparam int NM = 4;
  localparam int PW = 12;
  localparam int OW = 27;
  localparam int IB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic busy;

  always #5 clk = ~clk;

  global_io_accum_if #(.NUM_MACS(NM), .PSUM_WIDTH(PW), .GIO_OUT_WIDTH(OW)) bus ();

  global_io_accum #(
    .NUM_MACS(NM), .PSUM_WIDTH(PW), .GIO_OUT_WIDTH(OW), .IN_BITS(IB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int n_results = 0;
  int n_pushed  = 0;
  int cyc       = 0;
  int start_cyc;
  int res_mark;

  logic [OW-1:0] exp_q [$];
  logic [PW-1:0] vec_ps [IB][NM];
  logic [NM-1:0] beat_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: weighted sum of beat totals, MSB beat first.
  function automatic logic [OW-1:0] model(input logic sg, input logic [NM-1:0] mask);
    longint tot = 0;
    for (int b = 0; b < IB; b++) begin
      longint bs = 0;
      longint w;
      for (int m = 0; m < NM; m++) begin
        longint v = longint'($signed(vec_ps[b][m]));
        if (mask[m]) v = -v;
        bs += v;
      end
      w = longint'(1) << (IB - 1 - b);
      if (b == 0 && sg) tot -= bs * w;
      else              tot += bs * w;
    end
    return tot[OW-1:0];
  endfunction

  task automatic fill(input int val);
    for (int b = 0; b < IB; b++)
      for (int m = 0; m < NM; m++)
        vec_ps[b][m] = val[PW-1:0];
  endtask

  task automatic drive_beat(input int b, input logic sg);
    int guard = 0;
    for (int m = 0; m < NM; m++) bus.macout[m*PW +: PW] = vec_ps[b][m];
    bus.signed_op = sg;
`ifdef GIO_PAIR_SUB_EN
    bus.sub_mask = beat_mask;
`endif
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", guard, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vector(input logic sg);
    exp_q.push_back(model(sg, beat_mask));
    n_pushed++;
    for (int b = 0; b < IB; b++) drive_beat(b, sg);
  endtask

  task automatic wait_result(input string tag, input logic [OW-1:0] exp);
    int g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk(tag, bus.out_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("out_data", bus.out_data, exp_q.pop_front());
      n_results++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.macout    = '0;
    bus.signed_op = 1'b0;
    bus.out_ready = 1'b1;
    beat_mask     = '0;
`ifdef GIO_PAIR_SUB_EN
    bus.sub_mask  = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned ones, exact two-cycle latency.
    fill(1);
    send_vector(1'b0);
    @(negedge clk);
    chk("lat_t1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", bus.out_valid, 1);
    chk("ones_unsigned", bus.out_data, 27'd1020);
    @(posedge clk); #1;

    // Signed ones: MSB beat negative.
    fill(1);
    send_vector(1'b1);
    wait_result("ones_signed", 27'h7FFFFFC);

    // All -1, then back-to-back vector of twos with no idle cycle.
    start_cyc = cyc;
    fill(12'hFFF);
    send_vector(1'b0);
    fill(2);
    send_vector(1'b0);
    chk("b2b_cycles", cyc - start_cyc, 2*IB);
    drain();

    // Backpressure: first result refused while a second vector is in flight.
    bus.out_ready = 1'b0;
    fill(3);
    send_vector(1'b0);
    fill(1);
    fork
      send_vector(1'b0);
      begin
        int g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 20) begin
          @(negedge clk);
          g++;
        end
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", bus.in_ready, 0);
          chk("bp_hold", bus.out_data, 27'd3060);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_result("bp_second", 27'd1020);
    drain();

    // Clear after three beats, beat presented with clear is dropped.
    res_mark = n_results;
    fill(5);
    for (int b = 0; b < 3; b++) drive_beat(b, 1'b0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", busy, 0);
    chk("clear_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    fill(1);
    send_vector(1'b0);
    wait_result("after_clear", 27'd1020);
    drain();
    chk("clear_single_result", n_results - res_mark, 1);

    // Async reset with a held result and a partial vector.
    bus.out_ready = 1'b0;
    fill(1);
    for (int b = 0; b < IB; b++) drive_beat(b, 1'b0);
    drive_beat(0, 1'b0);
    @(negedge clk);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", bus.out_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_in_ready", bus.in_ready, 1);
    chk("rst_async_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    fill(2);
    send_vector(1'b1);
    wait_result("after_rst_signed", 27'h7FFFFF8);
    drain();

`ifdef GIO_PAIR_SUB_EN
    fill(1);
    beat_mask = 4'b1010;
    send_vector(1'b0);
    wait_result("sub_mask_cancel", 27'd0);
    beat_mask = '0;
    drain();
`endif

    // Random vectors under random downstream backpressure.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          logic sg;
          for (int b = 0; b < IB; b++)
            for (int m = 0; m < NM; m++)
              vec_ps[b][m] = PW'($urandom);
          sg = 1'($urandom_range(0, 1));
`ifdef GIO_PAIR_SUB_EN
          beat_mask = NM'($urandom);
`endif
          send_vector(sg);
        end
      end
      begin
        repeat (80) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("final_busy", busy, 0);
    chk("result_count", n_results, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
